// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared encodings for the 9-bit accumulator core: instruction type codes,
// per-type opcodes, instruction field positions, ALU operation codes and the
// write-back source select used by the execute stage.
// -----------------------------------------------------------------------------
package isa_pkg;

   // Instruction type, instr[8:7]
   typedef enum logic [1:0] {
      TYPE_R = 2'b00,
      TYPE_M = 2'b01,
      TYPE_B = 2'b10,
      TYPE_S = 2'b11
   } itype_e;

   // R-type op3
   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_ADD  = 3'b011;
   localparam logic [2:0] OP_SUB  = 3'b100;
   localparam logic [2:0] OP_SLT  = 3'b101;
   localparam logic [2:0] OP_SLTE = 3'b110;
   localparam logic [2:0] OP_SEQ  = 3'b111;

   // M-type op3
   localparam logic [2:0] OP_SB   = 3'b000;
   localparam logic [2:0] OP_LB   = 3'b001;
   localparam logic [2:0] OP_LL   = 3'b010;
   localparam logic [2:0] OP_LL2  = 3'b011;
   localparam logic [2:0] OP_LIL  = 3'b100;
   localparam logic [2:0] OP_LIU  = 3'b101;
   localparam logic [2:0] OP_LLM  = 3'b110;
   localparam logic [2:0] OP_NOP  = 3'b111;

   // B-type op2
   localparam logic [1:0] OP_BEQ  = 2'b00;
   localparam logic [1:0] OP_BLT  = 2'b01;
   localparam logic [1:0] OP_BLTE = 2'b10;
   localparam logic [1:0] OP_BUN  = 2'b11;

   // S-type op2
   localparam logic [1:0] OP_LSL  = 2'b00;
   localparam logic [1:0] OP_LSR  = 2'b01;
   localparam logic [1:0] OP_BF   = 2'b10;
   localparam logic [1:0] OP_BB   = 2'b11;

   // Field bit positions
   localparam int TYPE_HI = 8, TYPE_LO = 7;
   localparam int OP3_HI  = 6, OP3_LO  = 4;
   localparam int OP2_HI  = 6, OP2_LO  = 5;
   localparam int D_HI    = 3, D_LO    = 2;
   localparam int S_HI    = 1, S_LO    = 0;
   localparam int IMM5_HI = 4, IMM5_LO = 0;
   localparam int IMM4_HI = 3, IMM4_LO = 0;
   localparam int SHD_HI  = 4, SHD_LO  = 3;
   localparam int SHA_HI  = 2, SHA_LO  = 1;

   // ALU operations; codes 0..7 match the R-type op3 values on purpose
   typedef enum logic [3:0] {
      ALU_AND  = 4'd0,
      ALU_OR   = 4'd1,
      ALU_XOR  = 4'd2,
      ALU_ADD  = 4'd3,
      ALU_SUB  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTE = 4'd6,
      ALU_SEQ  = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9
   } alu_op_e;

   // Write-back data source
   typedef enum logic [2:0] {
      WB_ALU,
      WB_MEM,
      WB_LUT,
      WB_LIL,
      WB_LIU
   } wb_sel_e;

endpackage

// File: rtl/alu_ctrl_dmem_alu8.sv
// -----------------------------------------------------------------------------
// alu8
// Combinational 8-bit ALU. Unsigned compares, modulo-256 arithmetic,
// zero-filling shifts by the low SHAMT_W bits of b.
//   op     : ALU operation
//   a, b   : operands (a = rs, b = rt / shift amount)
//   result : ALU result
//   carry  : ADD carry-out or SUB borrow, 0 for every other op
//   eq, lt : a == b, a < b (unsigned), always valid
// -----------------------------------------------------------------------------
module alu8
   import isa_pkg::*;
#(
   parameter int SHAMT_W = 3
) (
   input  alu_op_e    op,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] result,
   output logic       carry,
   output logic       eq,
   output logic       lt
);

   always_comb begin
      // NOTE: every output gets a default first so no path through the case
      // leaves a value unassigned, which would infer a latch.
      result = '0;
      carry  = 1'b0;
      eq     = (a == b);
      lt     = (a < b);
      unique case (op)
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
         // Bit 8 of the 9-bit difference is the borrow (set when a < b)
         ALU_SUB:  {carry, result} = {1'b0, a} - {1'b0, b};
         ALU_SLT:  result = {7'd0, lt};
         ALU_SLTE: result = {7'd0, lt | eq};
         ALU_SEQ:  result = {7'd0, eq};
         ALU_SLL:  result = a << b[SHAMT_W-1:0];
         ALU_SRL:  result = a >> b[SHAMT_W-1:0];
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_dmem.sv
// -----------------------------------------------------------------------------
// alu_ctrl_dmem
// Execute stage of the 9-bit accumulator core: instruction decode, ALU with a
// registered compare-flag pair, and a byte-wide data memory.
//   clk, reset            : clock, synchronous active-high reset
//   instr                 : current instruction
//   rs_data, rt_data      : register-file read data for rd_addr1 / rd_addr2
//   lut_value             : external LUT ROM data for lut_index
//   rd_addr1, rd_addr2    : register-file read addresses
//   reg_write, wb_addr,
//   wb_data               : register-file write port
//   lut_index             : LUT ROM index (branch target or LL/LL2 index)
//   branch_en, branch_back: PC load enable and backward-offset select
//   mem_write, mem_read   : store / load strobes
//   alu_result, carry     : raw ALU outputs
//   flag_eq, flag_lt      : registered compare flags
// -----------------------------------------------------------------------------
module alu_ctrl_dmem
   import isa_pkg::*;
#(
   parameter int DMEM_DEPTH = 256,
   parameter int SHAMT_W    = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [8:0] instr,
   input  logic [7:0] rs_data,
   input  logic [7:0] rt_data,
   input  logic [7:0] lut_value,
   output logic [1:0] rd_addr1,
   output logic [1:0] rd_addr2,
   output logic       reg_write,
   output logic [1:0] wb_addr,
   output logic [7:0] wb_data,
   output logic [4:0] lut_index,
   output logic       branch_en,
   output logic       branch_back,
   output logic       mem_write,
   output logic       mem_read,
   output logic [7:0] alu_result,
   output logic       carry,
   output logic       flag_eq,
   output logic       flag_lt
);

   itype_e     itype;
   logic [2:0] op3;
   logic [1:0] op2;
   logic [1:0] fld_d;
   logic [1:0] fld_s;
   logic [4:0] imm5;
   logic [3:0] imm4;

   alu_op_e    alu_op;
   wb_sel_e    wb_sel;
   logic       flag_we;
   logic       lut_we;
   logic       alu_eq;
   logic       alu_lt;
   logic [7:0] lut_reg;
   logic [7:0] mem [DMEM_DEPTH];

   assign itype = itype_e'(instr[TYPE_HI:TYPE_LO]);
   assign op3   = instr[OP3_HI:OP3_LO];
   assign op2   = instr[OP2_HI:OP2_LO];
   assign fld_d = instr[D_HI:D_LO];
   assign fld_s = instr[S_HI:S_LO];
   assign imm5  = instr[IMM5_HI:IMM5_LO];
   assign imm4  = instr[IMM4_HI:IMM4_LO];

   alu8 #(.SHAMT_W(SHAMT_W)) u_alu (
      .op     (alu_op),
      .a      (rs_data),
      .b      (rt_data),
      .result (alu_result),
      .carry  (carry),
      .eq     (alu_eq),
      .lt     (alu_lt)
   );

   // Decoder. The default ALU op is AND so carry reads 0 outside ADD/SUB.
   always_comb begin
      rd_addr1    = '0;
      rd_addr2    = '0;
      reg_write   = 1'b0;
      wb_addr     = '0;
      wb_sel      = WB_ALU;
      lut_index   = '0;
      branch_en   = 1'b0;
      branch_back = 1'b0;
      mem_write   = 1'b0;
      mem_read    = 1'b0;
      alu_op      = ALU_AND;
      flag_we     = 1'b0;
      lut_we      = 1'b0;
      unique case (itype)
         TYPE_R: begin
            rd_addr1  = fld_d;
            rd_addr2  = fld_s;
            reg_write = 1'b1;
            wb_addr   = fld_d;
            alu_op    = alu_op_e'({1'b0, op3});
            flag_we   = (op3 >= OP_SLT);
         end
         TYPE_M: begin
            rd_addr1 = fld_d;
            rd_addr2 = fld_s;
            unique case (op3)
               OP_SB:  mem_write = 1'b1;
               OP_LB: begin
                  reg_write = 1'b1;
                  wb_addr   = fld_d;
                  wb_sel    = WB_MEM;
                  mem_read  = 1'b1;
               end
               OP_LL: begin
                  lut_index = {1'b0, imm4};
                  lut_we    = 1'b1;
               end
               OP_LL2: begin
                  lut_index = {1'b1, imm4};
                  lut_we    = 1'b1;
               end
               OP_LIL, OP_LIU: begin
                  rd_addr1  = 2'd0;
                  reg_write = 1'b1;
                  wb_addr   = 2'd0;
                  wb_sel    = (op3 == OP_LIL) ? WB_LIL : WB_LIU;
               end
               OP_LLM: begin
                  reg_write = 1'b1;
                  wb_addr   = fld_d;
                  wb_sel    = WB_LUT;
               end
               default: ;  // NOP
            endcase
         end
         TYPE_B: begin
            lut_index = imm5;
            unique case (op2)
               OP_BEQ:  branch_en = flag_eq;
               OP_BLT:  branch_en = flag_lt;
               OP_BLTE: branch_en = flag_eq | flag_lt;
               default: branch_en = 1'b1;  // BUN
            endcase
         end
         default: begin  // TYPE_S
            unique case (op2)
               OP_LSL, OP_LSR: begin
                  rd_addr1  = instr[SHD_HI:SHD_LO];
                  rd_addr2  = instr[SHA_HI:SHA_LO];
                  reg_write = 1'b1;
                  wb_addr   = instr[SHD_HI:SHD_LO];
                  alu_op    = (op2 == OP_LSL) ? ALU_SLL : ALU_SRL;
               end
               default: begin  // BF / BB
                  branch_en   = 1'b1;
                  branch_back = (op2 == OP_BB);
                  lut_index   = imm5;
               end
            endcase
         end
      endcase
   end

   // Write-back mux kept apart from the decoder so the decode -> ALU -> mux
   // path is not a single block reading its own outputs.
   always_comb begin
      unique case (wb_sel)
         WB_MEM:  wb_data = mem[rt_data];  // read sees the pre-store byte
         WB_LUT:  wb_data = lut_reg;
         WB_LIL:  wb_data = {rs_data[7:4], imm4};
         WB_LIU:  wb_data = {imm4, rs_data[3:0]};
         default: wb_data = alu_result;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         flag_eq <= 1'b0;
         flag_lt <= 1'b0;
         lut_reg <= '0;
         // NOTE: clearing the whole memory on reset forces it into flops;
         // an SRAM macro could not be reset this way.
         for (int i = 0; i < DMEM_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (flag_we) begin
            flag_eq <= alu_eq;
            flag_lt <= alu_lt;
         end
         if (lut_we)    lut_reg <= lut_value;
         if (mem_write) mem[rs_data] <= rt_data;
      end
   end

endmodule

// File: tb/tb_alu_ctrl_dmem.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_dmem
// Self-checking bench: directed scenarios followed by random instructions,
// compared against an instruction-level reference model.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_dmem;

   logic       clk = 1'b0;
   logic       reset;
   logic [8:0] instr;
   logic [7:0] rs_data, rt_data, lut_value;
   logic [1:0] rd_addr1, rd_addr2, wb_addr;
   logic       reg_write, branch_en, branch_back, mem_write, mem_read;
   logic       carry, flag_eq, flag_lt;
   logic [7:0] wb_data, alu_result;
   logic [4:0] lut_index;

   int tests = 0;
   int fails = 0;

   // Reference-model architectural state
   int m_eq, m_lt, m_lut;
   int m_mem [256];

   always #5 clk = ~clk;

   alu_ctrl_dmem dut (
      .clk(clk), .reset(reset), .instr(instr),
      .rs_data(rs_data), .rt_data(rt_data), .lut_value(lut_value),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .reg_write(reg_write),
      .wb_addr(wb_addr), .wb_data(wb_data), .lut_index(lut_index),
      .branch_en(branch_en), .branch_back(branch_back),
      .mem_write(mem_write), .mem_read(mem_read),
      .alu_result(alu_result), .carry(carry),
      .flag_eq(flag_eq), .flag_lt(flag_lt)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] r_ins(input int op, input int d, input int s);
      return {2'b00, 3'(op), 2'(d), 2'(s)};
   endfunction
   function automatic logic [8:0] m_ins(input int op, input int low4);
      return {2'b01, 3'(op), 4'(low4)};
   endfunction
   function automatic logic [8:0] b_ins(input int op, input int imm);
      return {2'b10, 2'(op), 5'(imm)};
   endfunction
   function automatic logic [8:0] s_ins(input int op, input int imm);
      return {2'b11, 2'(op), 5'(imm)};
   endfunction

   // One instruction: drive, check combinational outputs mid-cycle, clock,
   // then advance the model.
   task automatic step(input string name, input logic rst, input logic [8:0] ins,
                       input logic [7:0] rs, input logic [7:0] rt, input logic [7:0] lv);
      int typ, op3, op2, d, s, imm5, low4, a, b, amt;
      int e_rd1, e_rd2, e_rw, e_wa, e_wd, e_li, e_be, e_bb, e_mw, e_mr, e_c;
      int chk_rd1, chk_rd2, chk_alu, set_flags, set_lut;
      @(negedge clk);
      reset = rst; instr = ins; rs_data = rs; rt_data = rt; lut_value = lv;
      #1;
      typ  = int'(ins[8:7]); op3 = int'(ins[6:4]); op2 = int'(ins[6:5]);
      d    = int'(ins[3:2]); s   = int'(ins[1:0]);
      imm5 = int'(ins[4:0]); low4 = int'(ins[3:0]);
      a = int'(rs); b = int'(rt);
      e_rd1 = 0; e_rd2 = 0; e_rw = 0; e_wa = 0; e_wd = 0; e_li = 0; e_be = 0;
      e_bb = 0; e_mw = 0; e_mr = 0; e_c = 0;
      chk_rd1 = 0; chk_rd2 = 0; chk_alu = 0; set_flags = 0; set_lut = 0;
      if (typ == 0) begin
         e_rd1 = d; e_rd2 = s; chk_rd1 = 1; chk_rd2 = 1;
         e_rw = 1; e_wa = d; chk_alu = 1;
         case (op3)
            0: e_wd = a & b;
            1: e_wd = a | b;
            2: e_wd = a ^ b;
            3: begin e_wd = (a + b) % 256; e_c = (a + b > 255) ? 1 : 0; end
            4: begin e_wd = (a - b + 256) % 256; e_c = (a < b) ? 1 : 0; end
            5: e_wd = (a < b) ? 1 : 0;
            6: e_wd = (a <= b) ? 1 : 0;
            default: e_wd = (a == b) ? 1 : 0;
         endcase
         set_flags = (op3 >= 5) ? 1 : 0;
      end else if (typ == 1) begin
         case (op3)
            0: begin e_mw = 1; e_rd1 = d; e_rd2 = s; chk_rd1 = 1; chk_rd2 = 1; end
            1: begin e_rw = 1; e_wa = d; e_wd = m_mem[b]; e_mr = 1;
                     e_rd1 = d; e_rd2 = s; chk_rd1 = 1; chk_rd2 = 1; end
            2: begin e_li = low4; set_lut = 1; end
            3: begin e_li = 16 + low4; set_lut = 1; end
            4: begin chk_rd1 = 1; e_rw = 1; e_wd = (a / 16) * 16 + low4; end
            5: begin chk_rd1 = 1; e_rw = 1; e_wd = low4 * 16 + a % 16; end
            6: begin e_rw = 1; e_wa = d; e_wd = m_lut; end
            default: ;
         endcase
      end else if (typ == 2) begin
         e_li = imm5;
         case (op2)
            0: e_be = m_eq;
            1: e_be = m_lt;
            2: e_be = (m_eq != 0 || m_lt != 0) ? 1 : 0;
            default: e_be = 1;
         endcase
      end else begin
         if (op2 < 2) begin
            e_rd1 = imm5 / 8; e_rd2 = (imm5 / 2) % 4; chk_rd1 = 1; chk_rd2 = 1;
            e_rw = 1; e_wa = imm5 / 8; chk_alu = 1;
            amt = b % 8;
            e_wd = (op2 == 0) ? (a * (1 << amt)) % 256 : a / (1 << amt);
         end else begin
            e_be = 1; e_bb = (op2 == 3) ? 1 : 0; e_li = imm5;
         end
      end

      check({name, ".flag_eq"},     16'(flag_eq),     16'(m_eq));
      check({name, ".flag_lt"},     16'(flag_lt),     16'(m_lt));
      check({name, ".reg_write"},   16'(reg_write),   16'(e_rw));
      check({name, ".mem_write"},   16'(mem_write),   16'(e_mw));
      check({name, ".mem_read"},    16'(mem_read),    16'(e_mr));
      check({name, ".branch_en"},   16'(branch_en),   16'(e_be));
      check({name, ".branch_back"}, 16'(branch_back), 16'(e_bb));
      check({name, ".lut_index"},   16'(lut_index),   16'(e_li));
      check({name, ".carry"},       16'(carry),       16'(e_c));
      if (chk_rd1 != 0) check({name, ".rd_addr1"}, 16'(rd_addr1), 16'(e_rd1));
      if (chk_rd2 != 0) check({name, ".rd_addr2"}, 16'(rd_addr2), 16'(e_rd2));
      if (e_rw != 0) begin
         check({name, ".wb_addr"}, 16'(wb_addr), 16'(e_wa));
         check({name, ".wb_data"}, 16'(wb_data), 16'(e_wd));
      end
      if (chk_alu != 0) check({name, ".alu_result"}, 16'(alu_result), 16'(e_wd));

      @(posedge clk);
      if (rst) begin
         m_eq = 0; m_lt = 0; m_lut = 0;
         for (int i = 0; i < 256; i++) m_mem[i] = 0;
      end else begin
         if (set_flags != 0) begin
            m_eq = (a == b) ? 1 : 0;
            m_lt = (a < b) ? 1 : 0;
         end
         if (set_lut != 0) m_lut = int'(lv);
         if (e_mw != 0) m_mem[a] = b;
      end
   endtask

   initial begin
      logic [8:0] ri;
      logic [7:0] ra, rb;
      m_eq = 0; m_lt = 0; m_lut = 0;
      for (int i = 0; i < 256; i++) m_mem[i] = 0;
      reset = 1'b1; instr = m_ins(7, 0); rs_data = '0; rt_data = '0; lut_value = '0;
      repeat (2) @(posedge clk);

      // Reset state: flags clear, memory reads zero
      step("reset_lb", 0, m_ins(1, 4'b0100), 8'h00, 8'h40, 8'h00);

      // Arithmetic
      step("add",  0, r_ins(3, 1, 2), 8'd200, 8'd100, 8'h00);
      step("sub",  0, r_ins(4, 1, 2), 8'd5,   8'd7,   8'h00);
      step("xor",  0, r_ins(2, 0, 3), 8'hF0,  8'h3C,  8'h00);

      // Compare then branches on the latched flags
      step("slt",  0, r_ins(5, 3, 0), 8'd3, 8'd9, 8'h00);
      step("blt",  0, b_ins(1, 7), 8'h00, 8'h00, 8'h00);
      step("beq",  0, b_ins(0, 7), 8'h00, 8'h00, 8'h00);
      step("blte", 0, b_ins(2, 9), 8'h00, 8'h00, 8'h00);
      step("bun",  0, b_ins(3, 31), 8'h00, 8'h00, 8'h00);
      step("bf",   0, s_ins(2, 5), 8'h00, 8'h00, 8'h00);
      step("bb",   0, s_ins(3, 12), 8'h00, 8'h00, 8'h00);

      // Store then load from the same address
      step("sb",   0, m_ins(0, 4'b0001), 8'h40, 8'hA5, 8'h00);
      step("lb",   0, m_ins(1, 4'b1000), 8'h00, 8'h40, 8'h00);

      // LUT register path
      step("ll",      0, m_ins(2, 3), 8'h00, 8'h00, 8'h5C);
      step("lut_mov", 0, m_ins(6, 4'b1000), 8'h00, 8'h00, 8'h00);
      step("ll2",     0, m_ins(3, 3), 8'h00, 8'h00, 8'h11);

      // Immediate loads into R0
      step("lil",  0, m_ins(4, 4'hB), 8'h70, 8'h00, 8'h00);
      step("liu",  0, m_ins(5, 4'h2), 8'h7B, 8'h00, 8'h00);

      // Shifts: dest = 1, amount register = 2
      step("lsl",  0, s_ins(0, 5'b01_10_0), 8'h81, 8'd1, 8'h00);
      step("lsr",  0, s_ins(1, 5'b01_10_0), 8'h81, 8'd7, 8'h00);
      step("lsl0", 0, s_ins(0, 5'b11_01_1), 8'h5A, 8'hF8, 8'h00);

      // Reset beats a simultaneous compare and store
      step("sb2",     0, m_ins(0, 0), 8'h41, 8'h77, 8'h00);
      step("seq",     0, r_ins(7, 1, 1), 8'd5, 8'd5, 8'h00);
      step("rst_seq", 1, r_ins(7, 1, 1), 8'd5, 8'd5, 8'h00);
      step("rst_sb",  1, m_ins(0, 0), 8'h42, 8'h99, 8'h00);
      step("lb_41",   0, m_ins(1, 0), 8'h00, 8'h41, 8'h00);
      step("lb_42",   0, m_ins(1, 0), 8'h00, 8'h42, 8'h00);
      step("lb_40",   0, m_ins(1, 0), 8'h00, 8'h40, 8'h00);

      // Random instructions; operands often drawn from a small range so
      // loads hit stored addresses and equal compares occur.
      for (int n = 0; n < 400; n++) begin
         ri = 9'($urandom);
         ra = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
         rb = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
         step("rand", ($urandom_range(0, 49) == 0), ri, ra, rb, 8'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
